// File: rtl/orientation_scheduler.sv
// Walks a (2R+1)^2 window around each keypoint through the gradient_orientation
// unit, builds an 8-bin histogram of the returned bins and reports its argmax.
module orientation_scheduler #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int RADIUS = 2,
  localparam int X_W   = $clog2(WIDTH),
  localparam int Y_W   = $clog2(HEIGHT),
  localparam int CNT_W = $clog2((2*RADIUS+1)*(2*RADIUS+1)+1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [X_W-1:0]   kp_x,
  input  logic [Y_W-1:0]   kp_y,
  input  logic             kp_valid,
  output logic             kp_ready,
  output logic [X_W-1:0]   orient_center_x,
  output logic [Y_W-1:0]   orient_center_y,
  output logic             orient_valid_in,
  input  logic             orient_valid_out,
  input  logic [2:0]       orient_bin,
  output logic             valid_out,
  output logic [2:0]       dominant_bin,
  output logic [CNT_W-1:0] peak_count,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIND_MAX, S_DONE} state_t;

  localparam logic signed [X_W:0] R_X     = (X_W+1)'(RADIUS);
  localparam logic signed [Y_W:0] R_Y     = (Y_W+1)'(RADIUS);
  localparam logic signed [X_W:0] ONE_X   = (X_W+1)'(1);
  localparam logic signed [Y_W:0] ONE_Y   = (Y_W+1)'(1);
  localparam logic [X_W:0]        WIDTH_L  = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0]        HEIGHT_L = (Y_W+1)'(HEIGHT);

  state_t              r_state, w_next;
  logic [X_W-1:0]      r_kp_x;
  logic [Y_W-1:0]      r_kp_y;
  logic signed [X_W:0] r_dx;
  logic signed [Y_W:0] r_dy;
  logic [CNT_W-1:0]    r_hist [8];
  logic [2:0]          r_bin_idx;
  logic [2:0]          r_max_bin;
  logic [CNT_W-1:0]    r_max_cnt;
  logic [X_W-1:0]      r_center_x;
  logic [Y_W-1:0]      r_center_y;
  logic                r_valid_in;
  logic                r_valid_out;
  logic [2:0]          r_dominant_bin;
  logic [CNT_W-1:0]    r_peak_count;

  logic signed [X_W:0] w_px;
  logic signed [Y_W:0] w_py;
  logic                w_in_img;
  logic                w_last;
  logic                w_issue;
  logic                w_advance;
  logic                w_take;
  logic [2:0]          w_new_bin;
  logic [CNT_W-1:0]    w_new_cnt;

  // Coordinates are one bit wider than the image so negative offsets show up as a set sign bit.
  assign w_px      = $signed({1'b0, r_kp_x}) + r_dx;
  assign w_py      = $signed({1'b0, r_kp_y}) + r_dy;
  assign w_in_img  = !w_px[X_W] && ($unsigned(w_px) < WIDTH_L) &&
                     !w_py[Y_W] && ($unsigned(w_py) < HEIGHT_L);
  assign w_last    = (r_dx == R_X) && (r_dy == R_Y);
  assign w_take    = r_hist[r_bin_idx] > r_max_cnt;
  assign w_new_bin = w_take ? r_bin_idx : r_max_bin;
  assign w_new_cnt = w_take ? r_hist[r_bin_idx] : r_max_cnt;

  assign kp_ready        = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign orient_center_x = r_center_x;
  assign orient_center_y = r_center_y;
  assign orient_valid_in = r_valid_in;
  assign valid_out       = r_valid_out;
  assign dominant_bin    = r_dominant_bin;
  assign peak_count      = r_peak_count;

  // Next-state and per-cycle control decode.
  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (kp_valid) w_next = S_ISSUE;
        else          w_next = S_IDLE;
      end
      S_ISSUE: begin
        if (w_in_img) begin
          w_issue = 1'b1;
          w_next  = S_WAIT;
        end else begin
          w_advance = 1'b1;
          w_next    = w_last ? S_FIND_MAX : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (orient_valid_out) begin
          w_advance = 1'b1;
          w_next    = w_last ? S_FIND_MAX : S_ISSUE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_FIND_MAX: begin
        if (r_bin_idx == 3'd7) w_next = S_DONE;
        else                   w_next = S_FIND_MAX;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Window walk, histogram accumulation, argmax scan and result registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_kp_x         <= '0;
      r_kp_y         <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_bin_idx      <= 3'd0;
      r_max_bin      <= 3'd0;
      r_max_cnt      <= '0;
      r_center_x     <= '0;
      r_center_y     <= '0;
      r_valid_in     <= 1'b0;
      r_valid_out    <= 1'b0;
      r_dominant_bin <= 3'd0;
      r_peak_count   <= '0;
      for (int i = 0; i < 8; i++) r_hist[i] <= '0;
    end else begin
      r_valid_in  <= w_issue;
      r_valid_out <= 1'b0;
      if (w_issue) begin
        r_center_x <= w_px[X_W-1:0];
        r_center_y <= w_py[Y_W-1:0];
      end
      if (w_advance) begin
        if (r_dx == R_X) begin
          r_dx <= -R_X;
          r_dy <= r_dy + ONE_Y;
        end else begin
          r_dx <= r_dx + ONE_X;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (kp_valid) begin
            r_kp_x    <= kp_x;
            r_kp_y    <= kp_y;
            r_dx      <= -R_X;
            r_dy      <= -R_Y;
            r_bin_idx <= 3'd0;
            r_max_bin <= 3'd0;
            r_max_cnt <= '0;
            for (int i = 0; i < 8; i++) r_hist[i] <= '0;
          end
        end
        S_WAIT: begin
          if (orient_valid_out) r_hist[orient_bin] <= r_hist[orient_bin] + CNT_W'(1);
        end
        S_FIND_MAX: begin
          // Strict compare keeps the lowest index on ties; the final step feeds the outputs directly.
          r_max_bin <= w_new_bin;
          r_max_cnt <= w_new_cnt;
          r_bin_idx <= r_bin_idx + 3'd1;
          if (r_bin_idx == 3'd7) begin
            r_dominant_bin <= w_new_bin;
            r_peak_count   <= w_new_cnt;
            r_valid_out    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_orientation_scheduler.sv
// Scoreboard bench for orientation_scheduler with a variable-latency orientation-unit model.
module tb_orientation_scheduler;
  localparam int W  = 64;
  localparam int H  = 64;
  localparam int R  = 2;
  localparam int CW = $clog2((2*R+1)*(2*R+1)+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    kp_x, kp_y;
  logic          kp_valid, kp_ready;
  logic [5:0]    orient_center_x, orient_center_y;
  logic          orient_valid_in, orient_valid_out;
  logic [2:0]    orient_bin;
  logic          valid_out;
  logic [2:0]    dominant_bin;
  logic [CW-1:0] peak_count;
  logic          busy;
  logic          model_vo, spur_vo;
  logic [2:0]    model_bin, spur_bin;

  assign orient_valid_out = model_vo | spur_vo;
  assign orient_bin       = spur_vo ? spur_bin : model_bin;

  orientation_scheduler #(.WIDTH(W), .HEIGHT(H), .RADIUS(R)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .kp_x(kp_x), .kp_y(kp_y), .kp_valid(kp_valid),
    .kp_ready(kp_ready), .orient_center_x(orient_center_x), .orient_center_y(orient_center_y),
    .orient_valid_in(orient_valid_in), .orient_valid_out(orient_valid_out), .orient_bin(orient_bin),
    .valid_out(valid_out), .dominant_bin(dominant_bin), .peak_count(peak_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int bin; int cnt; int lat; int acc;} res_t;
  typedef struct {int x; int y;} ctr_t;

  res_t q_res[$];
  ctr_t q_ctr[$];
  int   q_bins[$];
  int   pat[25];
  int   checks = 0, failures = 0;
  int   cyc = 0, vi_count = 0, vo_count = 0, last_vo_cyc = -100, last_acc = 0;
  int   lat_l = 8, epoch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fill_const(input int b);
    for (int i = 0; i < 25; i++) pat[i] = b;
  endfunction

  function automatic void fill_rand();
    for (int i = 0; i < 25; i++) pat[i] = int'($urandom_range(0, 7));
  endfunction

  function automatic void fill_tie(input int a, input int b, input int c);
    int t, j;
    for (int i = 0; i < 25; i++) pat[i] = (i < 12) ? a : ((i < 24) ? b : c);
    for (int i = 24; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = pat[i]; pat[i] = pat[j]; pat[j] = t;
    end
  endfunction

  // Orientation-unit model: done pulse lands in the L-th cycle of the wait, bins from q_bins.
  initial begin
    model_vo = 1'b0;
    model_bin = 3'd0;
    forever begin
      int e;
      @(posedge clk);
      if (orient_valid_in === 1'b1 && rst_n === 1'b1) begin
        e = epoch;
        repeat (lat_l - 2) @(posedge clk);
        if (e == epoch) begin
          #1;
          model_bin = (q_bins.size() > 0) ? 3'(q_bins.pop_front()) : 3'd0;
          model_vo = 1'b1;
          @(posedge clk);
          #1 model_vo = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected centers and results whenever the DUT presents them.
  initial begin
    forever begin
      ctr_t c;
      res_t r;
      @(negedge clk);
      if (orient_valid_in === 1'b1) begin
        vi_count++;
        if (q_ctr.size() == 0) check("center_unexpected", 1, 0);
        else begin
          c = q_ctr.pop_front();
          check("center_x", int'(orient_center_x), c.x);
          check("center_y", int'(orient_center_y), c.y);
        end
      end
      if (valid_out === 1'b1) begin
        vo_count++;
        last_vo_cyc = cyc;
        if (q_res.size() == 0) check("result_unexpected", 1, 0);
        else begin
          r = q_res.pop_front();
          check("dominant_bin", int'(dominant_bin), r.bin);
          check("peak_count", int'(peak_count), r.cnt);
          check("latency", cyc - r.acc + 1, r.lat);
        end
      end
    end
  end

  task automatic send_kp(input int x, input int y);
    int guard, nin, nout, px, py, mx, mb;
    int hist[8];
    res_t r;
    @(negedge clk);
    kp_x = 6'(x); kp_y = 6'(y); kp_valid = 1'b1;
    guard = 0;
    while (kp_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      check("kp_accept_timeout", 0, 1);
      kp_valid = 1'b0;
      return;
    end
    nin = 0; nout = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    for (int dy = -R; dy <= R; dy++)
      for (int dx = -R; dx <= R; dx++) begin
        px = x + dx; py = y + dy;
        if (px >= 0 && px < W && py >= 0 && py < H) begin
          q_ctr.push_back('{px, py});
          q_bins.push_back(pat[nin]);
          hist[pat[nin]]++;
          nin++;
        end else nout++;
      end
    mx = 0;
    for (int i = 0; i < 8; i++) if (hist[i] > mx) mx = hist[i];
    mb = -1;
    for (int i = 0; i < 8; i++) if (mb < 0 && hist[i] == mx) mb = i;
    r = '{mb, mx, 1 + nin * (lat_l + 1) + nout + 8 + 1, cyc};
    q_res.push_back(r);
    last_acc = cyc;
    @(posedge clk);
    #1 kp_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (q_res.size() > 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("result_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, vo0, g;
    rst_n = 1'b0; kp_valid = 1'b0; kp_x = 6'd0; kp_y = 6'd0;
    spur_vo = 1'b0; spur_bin = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_kp_ready", int'(kp_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_valid_in", int'(orient_valid_in), 0);
    check("rst_center_x", int'(orient_center_x), 0);
    check("rst_center_y", int'(orient_center_y), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_dominant", int'(dominant_bin), 0);
    check("rst_peak", int'(peak_count), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_issue", vi_count, 0);

    // Interior and corner keypoints, constant bin 3, L=8.
    lat_l = 8; fill_const(3); v0 = vi_count;
    send_kp(10, 10); wait_done();
    check("interior_pulses", vi_count - v0, 25);
    fill_const(3); v0 = vi_count;
    send_kp(0, 0); wait_done();
    check("corner_pulses", vi_count - v0, 9);

    // Tie between bins 5 and 2 resolves to the lower index.
    fill_tie(5, 2, 7);
    send_kp(20, 20); wait_done();

    // Backpressure: second keypoint held until the cycle after valid_out.
    lat_l = 5; fill_rand();
    send_kp(40, 12);
    check("busy_while_processing", int'(busy), 1);
    fill_const(0);
    send_kp(41, 13);
    check("bp_accept_cycle", last_acc, last_vo_cyc + 1);
    wait_done();

    // Spurious done pulse with bin 6 while idle.
    @(negedge clk); spur_bin = 3'd6; spur_vo = 1'b1;
    @(negedge clk); spur_vo = 1'b0;
    repeat (2) @(negedge clk);
    lat_l = 8; fill_tie(4, 6, 0);
    send_kp(33, 33); wait_done();

    // Randomized keypoints, biased toward the image borders.
    for (int k = 0; k < 8; k++) begin
      int x, y;
      lat_l = int'($urandom_range(2, 10));
      fill_rand();
      case ($urandom_range(0, 3))
        0: x = 0;
        1: x = W - 1;
        2: x = int'($urandom_range(0, 2));
        default: x = int'($urandom_range(0, W - 1));
      endcase
      y = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, H - 1)) : H - 1 - int'($urandom_range(0, 2));
      send_kp(x, y); wait_done();
    end

    // Reset during WAIT at the 10th position, then verify no stale counts.
    lat_l = 8; fill_const(0); v0 = vi_count;
    send_kp(30, 30);
    g = 0;
    while (vi_count < v0 + 10 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("abort_reached_10th", vi_count - v0, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    epoch++;
    q_res.delete(); q_ctr.delete(); q_bins.delete();
    vo0 = vo_count;
    repeat (3) @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_peak", int'(peak_count), 0);
    check("abort_valid_in", int'(orient_valid_in), 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_valid_out", vo_count - vo0, 0);
    fill_const(1);
    send_kp(30, 30); wait_done();

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
